// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: diff = a - b - b_in (mod 2^WIDTH), computed
//   LSB first with a single full-subtractor cell. The operands are shifted right
//   through the cell, and the result bits are shifted in from the MSB side.
//   A start/busy/done handshake frames each operation.
//
//   Optional feature macro: SUB_OVF_EN
//     When defined, adds the `ovf` output, which flags two's-complement overflow
//     of the final result. When undefined, there is no port and no logic for it.
//
// Ports
//   sys_clk  in   system clock, rising edge
//   sys_rst  in   asynchronous active-high reset
//   start    in   operation request, sampled only in IDLE
//   a        in   minuend, latched when start is accepted
//   b        in   subtrahend, latched when start is accepted
//   b_in     in   borrow in, latched when start is accepted
//   busy     out  high while bits are being processed
//   done     out  one-cycle pulse; diff/b_out (and ovf) are freshly valid
//   diff     out  a - b - b_in mod 2^WIDTH, held until the next done
//   b_out    out  final borrow (a < b + b_in, unsigned)
//   ovf      out  (SUB_OVF_EN only) signed overflow of the subtraction
module serial_subtractor #(
  parameter int WIDTH = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SUB_OVF_EN
  output logic             b_out,
  output logic             ovf
`else
  output logic             b_out
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_brw;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic               r_busy;
  logic               r_done;

  logic               w_last;
  logic               w_d;
  logic               w_brw;
  logic [WIDTH-1:0]   w_res_nxt;

  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  // Full-subtractor cell on the current LSBs of the shifting operands.
  assign w_d       = r_a[0] ^ r_b[0] ^ r_brw;
  assign w_brw     = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CALC;
          w_load      = 1'b1;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register. busy/done are registered from the next state so that they
  // line up exactly with the state they describe.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_CALC);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Datapath: operand shift registers, running borrow, partial result, and the
  // output registers, which change only on the final bit.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_load) begin
      r_a   <= a;
      r_b   <= b;
      r_brw <= b_in;
      r_cnt <= '0;
      r_res <= '0;
    end else if (r_state == S_CALC) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_brw <= w_brw;
      r_cnt <= r_cnt + CNT_W'(1);
      r_res <= w_res_nxt;
      if (w_last) begin
        r_diff <= w_res_nxt;
        r_bout <= w_brw;
      end
    end
  end

`ifdef SUB_OVF_EN
  // The operand MSBs are shifted out during the operation, so keep copies for
  // the overflow decision made on the final bit.
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if ((r_state == S_CALC) && w_last) begin
      // Signed overflow: operand signs differ and the result sign differs from a.
      r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy  = r_busy;
  assign done  = r_done;
  assign diff  = r_diff;
  assign b_out = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       sys_clk;
  logic       sys_rst;
  logic       start;
  logic [2:0] a;
  logic [2:0] b;
  logic       b_in;
  logic       busy;
  logic       done;
  logic [2:0] diff;
  logic       b_out;
`ifdef SUB_OVF_EN
  logic       ovf;
`endif

  serial_subtractor #(.WIDTH(3)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
`ifdef SUB_OVF_EN
    .b_out   (b_out),
    .ovf     (ovf)
`else
    .b_out   (b_out)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [2:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge sys_clk) begin
    if (!sys_rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", int'(diff), int'(e.d));
        check("b_out", int'(b_out), int'(e.bo));
`ifdef SUB_OVF_EN
        check("ovf", int'(ovf), int'(e.ov));
`endif
      end
    end
  end

  // Issue one operation, expect done WIDTH edges after acceptance with busy
  // high for exactly WIDTH sampled cycles, then settle back into IDLE.
  task automatic do_op(input logic [2:0] ta, input logic [2:0] tb, input logic tbin,
                       input logic [2:0] ed, input logic ebo, input logic eov);
    int n_busy;
    int lat;
    bit got;
    @(negedge sys_clk);
    a = ta; b = tb; b_in = tbin; start = 1'b1;
    sb.push_back('{d: ed, bo: ebo, ov: eov});
    @(posedge sys_clk);
    #1 start = 1'b0;
    n_busy = 0; lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge sys_clk);
      lat++;
      if (done) got = 1'b1;
      else if (busy) n_busy++;
    end
    check("done_seen", int'(got), 1);
    check("done_edge", lat - 1, 3);
    check("busy_cycles", n_busy, 3);
    @(negedge sys_clk);
  endtask

  // Vector table: a, b, b_in, expected diff, b_out, ovf (all hand-computed).
  typedef struct packed {
    logic [2:0] ta;
    logic [2:0] tb;
    logic       bin;
    logic [2:0] ed;
    logic       ebo;
    logic       eov;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n_done;
    int k_done[$];
    vecs[0] = '{ta: 3'b010, tb: 3'b001, bin: 1'b0, ed: 3'b001, ebo: 1'b0, eov: 1'b0};
    vecs[1] = '{ta: 3'b001, tb: 3'b010, bin: 1'b0, ed: 3'b111, ebo: 1'b1, eov: 1'b0};
    vecs[2] = '{ta: 3'b000, tb: 3'b000, bin: 1'b1, ed: 3'b111, ebo: 1'b1, eov: 1'b0};
    vecs[3] = '{ta: 3'b011, tb: 3'b111, bin: 1'b0, ed: 3'b100, ebo: 1'b1, eov: 1'b1};
    vecs[4] = '{ta: 3'b100, tb: 3'b001, bin: 1'b1, ed: 3'b010, ebo: 1'b0, eov: 1'b1};
    vecs[5] = '{ta: 3'b010, tb: 3'b101, bin: 1'b1, ed: 3'b100, ebo: 1'b1, eov: 1'b1};

    sys_rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_diff", int'(diff), 0);
    check("rst_bout", int'(b_out), 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Directed vectors
    foreach (vecs[i])
      do_op(vecs[i].ta, vecs[i].tb, vecs[i].bin, vecs[i].ed, vecs[i].ebo, vecs[i].eov);

    // Start pulsed while busy must be ignored
    @(negedge sys_clk);
    a = 3'b111; b = 3'b111; b_in = 1'b0; start = 1'b1;
    sb.push_back('{d: 3'b000, bo: 1'b0, ov: 1'b0});
    @(posedge sys_clk);
    #1 start = 1'b0;
    @(negedge sys_clk);
    a = 3'b001; b = 3'b000; start = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      if (done) n_done++;
    end
    check("ignored_start_dones", n_done, 1);

    // Reset in the middle of an operation
    @(negedge sys_clk);
    a = 3'b010; b = 3'b001; b_in = 1'b0; start = 1'b1;
    @(posedge sys_clk);
    #1 start = 1'b0;
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_diff", int'(diff), 0);
    check("abort_bout", int'(b_out), 0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    do_op(3'b101, 3'b011, 1'b0, 3'b010, 1'b0, 1'b1);

    // start held high for 12 edges: back-to-back ops every 5 edges
    @(negedge sys_clk);
    a = 3'b110; b = 3'b001; b_in = 1'b0; start = 1'b1;
    repeat (3) sb.push_back('{d: 3'b101, bo: 1'b0, ov: 1'b0});
    for (int k = 1; k <= 18; k++) begin
      @(negedge sys_clk);
      if (done) k_done.push_back(k);
      if (k == 12) start = 1'b0;
    end
    check("held_done_count", k_done.size(), 3);
    if (k_done.size() == 3) begin
      check("held_first_done", k_done[0], 4);
      check("held_spacing_1", k_done[1] - k_done[0], 5);
      check("held_spacing_2", k_done[2] - k_done[1], 5);
    end

    repeat (4) @(negedge sys_clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
